mmm_core: RTL and testbench

Self-sequenced, parametrised Montgomery modular multiplier for the RSA peripheral. It computes R = A·B·2^-WIDTH mod M for odd M and fully reduces the result into [0, M). A single start pulse launches the operation; an internal controller drives the bit-serial datapath, the peripheral register block needs no external load/lock sequencing, and completion is signalled with a one-cycle done pulse. It sits beneath the RSA exponentiation controller and replaces hand-sequenced multiplier use.

---
 rtl/mmm_pkg.sv | 12 +
 rtl/mmm_step.sv | 53 +++++
 rtl/mmm_core.sv | 95 +++++++++
 tb/tb_mmm_core.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared types for the Montgomery modular multiplier.
// Holds the controller state encoding used by mmm_core.
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mmm_step.sv
// One bit-serial Montgomery iteration: q, operand select, add, halve.
// Ports: acc/a_i/b/m/bm in, acc_next out (all combinational).
module mmm_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   acc,
  input  logic             a_i,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH:0]   bm,
  output logic [WIDTH:0]   acc_next
);

  localparam int SW = WIDTH + 2;

  logic         q;
  logic [WIDTH:0] op;
  logic [SW-1:0]  x;
  logic [SW-1:0]  y;
  logic [SW-1:1]  s;
  logic [SW-1:1]  c;

  assign q = acc[0] ^ (a_i & b[0]);

  always_comb begin
    op = '0;
    unique case ({a_i, q})
      2'b00:   op = '0;
      2'b10:   op = {1'b0, b};
      2'b01:   op = {1'b0, m};
      default: op = bm;
    endcase
  end

  assign x = {1'b0, acc};
  assign y = {1'b0, op};

  // q forces an even sum, so bit 0 is always zero;
  // only its carry matters and it needs no sum bit.
  assign c[1] = x[0] & y[0];

  genvar i;
  for (i = 1; i < SW; i++) begin : g_fa
    assign s[i] = x[i] ^ y[i] ^ c[i];
    if (i < SW - 1) begin : g_c
      assign c[i+1] = (x[i] & y[i])
                    | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign acc_next = s[SW-1:1];

endmodule

// File: rtl/mmm_core.sv
// Self-sequenced Montgomery multiplier: R = A*B*2^-WIDTH mod M.
// Ports: clk, rstb, ena, clear, start, A, B, M in; busy, done, R out.
module mmm_core
  import mmm_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R
);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   bm_q;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic             last;

  mmm_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .a_i      (a_sh[0]),
    .b        (b_q),
    .m        (m_q),
    .bm       (bm_q),
    .acc_next (acc_nx)
  );

  // acc < 2M, so when acc >= M the difference
  // fits in WIDTH bits and the top bit can drop.
  assign ge   = acc >= {1'b0, m_q};
  assign diff = acc[WIDTH-1:0] - m_q;
  assign last = cnt == CNT_W'(WIDTH - 1);

  assign busy = (state == RUN) || (state == FIX);
  assign done = state == DONE;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
      a_sh  <= '0;
      b_q   <= '0;
      m_q   <= '0;
      bm_q  <= '0;
      acc   <= '0;
      cnt   <= '0;
      R     <= '0;
    end else if (clear) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      R     <= '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_q   <= B;
            m_q   <= M;
            bm_q  <= {1'b0, B} + {1'b0, M};
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_nx;
          a_sh <= a_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (last) state <= FIX;
        end
        FIX: begin
          R     <= ge ? diff : acc[WIDTH-1:0];
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_core.sv
// Directed bench for mmm_core at WIDTH=4 and WIDTH=8.
// Drives on negedge, samples on negedge; prints one summary.
module tb_mmm_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb, ena, clear;
  logic       start4, busy4, done4;
  logic [3:0] a4, b4, m4, r4;
  logic       start8, busy8, done8;
  logic [7:0] a8, b8, m8, r8;

  int checks = 0;
  int errors = 0;
  int fixcov = 0;

  mmm_core #(.WIDTH(4)) dut4 (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear),
    .start(start4), .A(a4), .B(b4), .M(m4),
    .busy(busy4), .done(done4), .R(r4)
  );

  mmm_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear),
    .start(start8), .A(a8), .B(b8), .M(m8),
    .busy(busy8), .done(done8), .R(r8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Reference: smallest r in [0,M) with r*2^w == A*B (mod M).
  function automatic int mont_ref(int a, int b, int m, int w);
    int t;
    t = (a * b) % m;
    for (int r = 0; r < m; r++)
      if (((r << w) % m) == t) return r;
    return -1;
  endfunction

  // Whether the unreduced REDC value lands in [M, 2M).
  function automatic bit needs_fix(int a, int b, int m, int w);
    int x;
    x = a * b;
    for (int k = 0; k < w; k++) begin
      if (x[0]) x = x + m;
      x = x >> 1;
    end
    return x >= m;
  endfunction

  // Caller sits on a negedge; returns on the done negedge.
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] m, input int exp,
                      input string tag, input bit poke);
    int cyc, bc;
    a4 = a; b4 = b; m4 = m; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); m4 = 4'($urandom);
    cyc = 1; bc = 0;
    while (!done4 && cyc < 20) begin
      if (busy4) bc++;
      start4 = poke && (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start4 = 1'b0;
    chk({tag, "_lat"}, cyc, 6);
    chk({tag, "_busyc"}, bc, 5);
    chk({tag, "_busy_at_done"}, busy4, 0);
    chk({tag, "_r"}, r4, exp);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] m, input int exp,
                      input string tag);
    int cyc, bc;
    a8 = a; b8 = b; m8 = m; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); m8 = 8'($urandom);
    cyc = 1; bc = 0;
    while (!done8 && cyc < 30) begin
      if (busy8) bc++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 10);
    chk({tag, "_busyc"}, bc, 9);
    chk({tag, "_r"}, r8, exp);
  endtask

  initial begin
    int seen, en_edges, guard, mm, aa, bb;
    bit prev;
    rstb = 1'b0; ena = 1'b1; clear = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; m4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_r4", r4, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_r8", r8, 0);
    rstb = 1'b1;
    @(negedge clk);

    run4(4'd5, 4'd7, 4'd13, 3, "w4_5x7", 1'b0);
    @(negedge clk);
    chk("done_one_cycle", done4, 0);
    chk("r_hold", r4, 3);
    run4(4'd3, 4'd1, 4'd13, 1, "w4_3x1", 1'b0);
    @(negedge clk);
    run4(4'd12, 4'd12, 4'd13, 9, "w4_12x12", 1'b0);

    // reset during FIX
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd7; m4 = 4'd13; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("fix_busy", busy4, 1);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    chk("rstfix_busy", busy4, 0);
    chk("rstfix_done", done4, 0);
    chk("rstfix_r", r4, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) seen++;
    end
    chk("rstfix_nodone", seen, 0);

    // start while busy must be ignored
    run4(4'd5, 4'd7, 4'd13, 3, "w4_poke", 1'b1);

    // clear in RUN cycle 3
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd7; m4 = 4'd13; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_busy", busy4, 0);
    chk("clr_r", r4, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) seen++;
    end
    chk("clr_nodone", seen, 0);

    run8(8'd0, 8'd200, 8'd239, 0, "w8_zero");

    for (int v = 0; v < 1000; v++) begin
      mm = $urandom_range(1, 127) * 2 + 1;
      aa = $urandom_range(0, mm - 1);
      bb = $urandom_range(0, mm - 1);
      if (needs_fix(aa, bb, mm, 8)) fixcov++;
      @(negedge clk);
      run8(8'(aa), 8'(bb), 8'(mm),
           mont_ref(aa, bb, mm, 8), "sweep");
    end
    chk("fix_coverage", fixcov > 0, 1);

    // random clock enable
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd7; m4 = 4'd13; ena = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    en_edges = 1; guard = 0;
    while (!done4 && guard < 100) begin
      ena = 1'($urandom_range(0, 1));
      prev = ena;
      @(negedge clk);
      if (prev) en_edges++;
      guard++;
    end
    chk("ena_edges", en_edges, 6);
    chk("ena_r", r4, 3);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    chk("ena_done_held", done4, 1);
    ena = 1'b1;
    @(negedge clk);
    chk("ena_done_drop", done4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
